// File: rtl/serial_frame_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/frame_shift_reg.sv
// WIDTH-bit deserialising shift register: sync clear, shift enable, direction select.
module frame_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             shift,
  input  logic             dir,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // dir=1 pushes new bits in at the LSB so the first bit ends up in the MSB.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (shift) begin
      if (dir) q <= {q[WIDTH-2:0], din};
      else     q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Optional parity stage enabled by defining SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             sin,
  input  logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);

  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic             order;
  logic [WIDTH-1:0] sh;
  logic             start_seen;
  logic             shift_en;
  logic             stop_edge;
  logic             stop_par_bad;

  assign start_seen = en && (state == IDLE) && (sin == START_BIT);
  assign shift_en   = en && (state == DATA);
  assign stop_edge  = en && (state == STOP);

  frame_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .clr   (clr),
    .clear (start_seen),
    .shift (shift_en),
    .dir   (order),
    .din   (sin),
    .q     (sh)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (en && (sin == START_BIT)) nxt = DATA;
      DATA: begin
        if (en && (cnt == LAST_BIT)) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
          nxt = PARITY;
`else
          nxt = STOP;
`endif
        end
      end
      PARITY: if (en) nxt = STOP;
      STOP:   if (en) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // busy mirrors the registered next state so it tracks the start/stop sample edges.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      order     <= 1'b0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= nxt;
      busy      <= (nxt != IDLE);
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (start_seen) begin
        cnt   <= '0;
        order <= sel;
      end else if (shift_en && (cnt != FULL_CNT)) begin
        cnt <= cnt + CW'(1);
      end
      if (stop_edge) begin
        if ((sin == STOP_BIT) && !stop_par_bad) begin
          dout  <= sh;
          valid <= 1'b1;
        end
        frame_err <= (sin != STOP_BIT);
      end
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_acc;
  logic par_bad;

  // Running XOR of the data bits; compared against the received even-parity bit.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= stop_edge && par_bad;
      if (start_seen) begin
        par_acc <= 1'b0;
        par_bad <= 1'b0;
      end else if (shift_en) begin
        par_acc <= par_acc ^ sin;
      end else if (en && (state == PARITY)) begin
        par_bad <= sin ^ par_acc;
      end
    end
  end

  assign stop_par_bad = par_bad;
`else
  assign stop_par_bad = 1'b0;
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: per-cycle vector table (directed + random frames) and a clr abort sequence.
module tb_serial_frame_rx;

  localparam int W = 4;

  logic         clk;
  logic         clr;
  logic         en;
  logic         sin;
  logic         sel;
  logic [W-1:0] dout;
  logic         valid;
  logic         busy;
  logic         frame_err;
  logic         parity_err;

  typedef struct {
    logic         en;
    logic         sin;
    logic         sel;
    logic [W-1:0] dout;
    logic         valid;
    logic         busy;
    logic         ferr;
    logic         perr;
  } vec_t;

  vec_t         vq[$];
  int           pass_cnt  = 0;
  int           total_cnt = 0;
  logic [W-1:0] mdl_dout;

  serial_frame_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .sin        (sin),
    .sel        (sel),
    .dout       (dout),
    .valid      (valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] d, input logic v, b, fe, pe);
    total_cnt++;
    if (dout !== d || valid !== v || busy !== b || frame_err !== fe || parity_err !== pe) begin
      $display("FAIL %s: got dout=%b valid=%b busy=%b ferr=%b perr=%b, expected dout=%b valid=%b busy=%b ferr=%b perr=%b",
               name, dout, valid, busy, frame_err, parity_err, d, v, b, fe, pe);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic add(input logic e, s, sl, input logic [W-1:0] d, input logic v, b, fe, pe);
    vec_t r;
    r.en = e; r.sin = s; r.sel = sl; r.dout = d;
    r.valid = v; r.busy = b; r.ferr = fe; r.perr = pe;
    vq.push_back(r);
  endtask

  // bits[W-1] goes on the line first; toggle inserts an en=0 cycle after every en=1 cycle.
  task automatic add_frame(input logic [W-1:0] bits, input logic sel0, sel_mid, stopb, par_flip, toggle,
                           input logic [W-1:0] dprev, dnew, input logic expv);
    logic pe;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    pe = par_flip;
`else
    pe = 1'b0;
`endif
    add(1'b1, 1'b0, sel0, dprev, 1'b0, 1'b1, 1'b0, 1'b0);
    if (toggle) add(1'b0, 1'b1, sel0, dprev, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) begin
      add(1'b1, bits[i], sel_mid, dprev, 1'b0, 1'b1, 1'b0, 1'b0);
      if (toggle) add(1'b0, ~bits[i], sel_mid, dprev, 1'b0, 1'b1, 1'b0, 1'b0);
    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
    add(1'b1, (^bits) ^ par_flip, sel_mid, dprev, 1'b0, 1'b1, 1'b0, 1'b0);
    if (toggle) add(1'b0, ~((^bits) ^ par_flip), sel_mid, dprev, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    add(1'b1, stopb, sel_mid, dnew, expv, 1'b0, ~stopb, pe);
    if (toggle) add(1'b0, 1'b1, sel_mid, dnew, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Word as the receiver should assemble it: first line bit to MSB (sel=1) or LSB (sel=0).
  function automatic logic [W-1:0] model_word(input logic [W-1:0] bits, input logic order);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) begin
      if (order) w[W-1-i] = bits[W-1-i];
      else       w[i]     = bits[W-1-i];
    end
    return w;
  endfunction

  task automatic apply_row(input vec_t r, input string name);
    @(negedge clk);
    en = r.en; sin = r.sin; sel = r.sel;
    @(posedge clk);
    #1;
    check(name, r.dout, r.valid, r.busy, r.ferr, r.perr);
  endtask

  task automatic apply_all(input string tag);
    for (int i = 0; i < vq.size(); i++) apply_row(vq[i], $sformatf("%s_row%0d", tag, i));
  endtask

  initial begin
    logic [W-1:0] bits;
    logic         rsel, rsel_mid, rstop, rflip, rtog, good, e;
    int           gap;

    clr = 1'b1; en = 1'b0; sin = 1'b1; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b0;

    // Directed frames
    add_frame(4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1011, 1'b1);
    add(1'b1, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    add_frame(4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 4'b1101, 1'b1);
    add(1'b1, 1'b1, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
    add_frame(4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1101, 4'b1011, 1'b1);
    add_frame(4'b1100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b1011, 1'b0);
    add_frame(4'b0011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011, 4'b1100, 1'b1);
    add(1'b1, 1'b1, 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    add_frame(4'b1011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1100, 4'b1100, 1'b0);
`endif
    mdl_dout = 4'b1100;

    // Random frames separated by random idle / stalled cycles
    for (int f = 0; f < 150; f++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        e = 1'($urandom_range(0, 1));
        add(e, e ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            mdl_dout, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      bits     = W'($urandom);
      rsel     = 1'($urandom_range(0, 1));
      rsel_mid = 1'($urandom_range(0, 1));
      rstop    = ($urandom_range(0, 3) != 0);
      rtog     = 1'($urandom_range(0, 1));
`ifdef SERIAL_FRAME_RX_PARITY_EN
      rflip    = ($urandom_range(0, 3) == 0);
`else
      rflip    = 1'b0;
`endif
      good = rstop && !rflip;
      add_frame(bits, rsel, rsel_mid, rstop, rflip, rtog, mdl_dout,
                good ? model_word(bits, rsel) : mdl_dout, good);
      if (good) mdl_dout = model_word(bits, rsel);
    end

    apply_all("vec");

    // clr mid-frame: abort after two data bits
    vq.delete();
    add(1'b1, 1'b0, 1'b1, mdl_dout, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, mdl_dout, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, mdl_dout, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_all("pre_clr");
    @(negedge clk);
    en = 1'b1; sin = 1'b1;
    clr = 1'b1;
    #2;
    check("clr_async", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("clr_held", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b0;

    vq.delete();
    add(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    add_frame(4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0110, 1'b1);
    add(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    add_frame(4'b0110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 4'b0110, 1'b0);
    add(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    apply_all("post_clr");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial-to-parallel frame receiver: the receive end of the team's serial shift link. Detects a start bit on a one-bit serial line, shifts in a parameterised number of data bits MSB-first or LSB-first, checks the stop bit, and presents the assembled word with a one-cycle valid strobe. It sits at the far end of a parallel-load shift-register transmitter and converts its serial stream back into words.

## Interface
- WIDTH, 4: data bits per frame (≥2)
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous, active-high reset
- en  input  1  bit strobe; line sampled only on edges where en=1
- sin  input  1  serial line, idle high
- sel  input  1  bit order; 1 = first data bit lands in MSB (left shift), 0 = first data bit lands in LSB (right shift)
- dout  output  WIDTH  last good word
- valid  output  1  one-cycle pulse, dout updated
- busy  output  1  frame in progress (state ≠ IDLE)
- frame_err  output  1  one-cycle pulse, stop bit was 0
- parity_err  output  1  one-cycle pulse, parity mismatch (see Configuration)

## Operation
- Frame on line: start bit 0, WIDTH data bits, [parity bit], stop bit 1.
- FSM states: IDLE, DATA, PARITY (only with macro), STOP.
- IDLE: en=1 and sin=0 → DATA; bit counter cleared; sel latched into internal order register; shift register cleared. sin=1 stays IDLE.
- DATA: each en=1 edge shifts sin in: order=1 → sh <= {sh[WIDTH-2:0], sin}; order=0 → sh <= {sin, sh[WIDTH-1:1]}. Counter increments; after the WIDTH-th bit → PARITY or STOP.
- STOP: on en=1 edge → IDLE. sin=1 and no parity error: dout <= sh, valid=1. sin=0: frame_err=1, dout holds. Parity error: parity_err=1, dout holds, valid=0. Both errors may pulse together.
- en=0: state, counter, shift register all hold; strobes low.
- sel changes mid-frame have no effect; order is fixed at the start bit.
- Counter width $clog2(WIDTH+1); no wrap past WIDTH.

## Timing
- Reset values: dout=0, valid=0, busy=0, frame_err=0, parity_err=0, state IDLE, counter 0, shift register 0.
- clr asserted mid-frame: immediate abort to reset values; partial word discarded; no strobe.
- All outputs registered. busy rises on the edge sampling the start bit, falls on the edge sampling the stop bit.
- valid/frame_err/parity_err asserted for exactly the one cycle following the stop-bit sample edge; dout valid from that same cycle and stable until the next good frame.
- Minimum frame: WIDTH+2 en-qualified edges (WIDTH+3 with parity). Back-to-back frames allowed: a start bit may be sampled on the en edge directly after the stop edge.

## Configuration
- SERIAL_FRAME_RX_PARITY_EN defined: PARITY state present; one even-parity bit follows the data bits; received bit must equal XOR of the data bits, else parity_err pulses at the stop edge.
- Not defined: no PARITY state, DATA → STOP directly; parity_err tied 0.

## Structure
- Package serial_frame_pkg: FSM state enum, IDLE_LEVEL=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module: frame_shift_reg (WIDTH-bit shift register with clear, enable, and direction input); FSM, counter and parity accumulator in the top.

## Test plan
- Reset: clr=1 for 2 cycles → dout=0000, valid=0, busy=0, both error flags 0.
- sel=1, en=1 constant, sin stream 0,1,0,1,1,1 (start, 1011, stop) → dout=1011, single valid pulse, busy high 5 cycles.
- sel=0, same stream → dout=1101, single valid pulse.
- Stream 0,1,1,0,0,0 (stop=0) after a good 1011 frame → frame_err pulse, valid=0, dout stays 1011.
- en toggling 1/0 every cycle with the 1011 frame → dout=1011; identical result to constant en; state holds on en=0 cycles.
- clr pulse after 2 data bits, then a full 0110 frame (sel=1) → dout=0 after clr, then dout=0110 with one valid pulse; with macro, same frame with wrong parity bit → parity_err pulse, dout unchanged.
